polygon_draw_sequencer: RTL and testbench
=========================================

POLYGON_DRAW_SEQUENCER -- requirements
Module: polygon_draw_sequencer

Interface
REQ-001 SHALL have parameter MAX_EDGES, default 4, maximum edges per shape (min 3).
REQ-002 SHALL have parameter COORD_W, default 10, coordinate width in bits.
REQ-003 SHALL have parameter GAP_CYCLES, default 1, idle cycles between consecutive edge draws (0 allowed).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port seq_en, input, 1, start request, sampled only in IDLE.
REQ-007 SHALL have port edge_count, input, $clog2(MAX_EDGES+1), 1 = open segment v0->v1; 3..MAX_EDGES = closed polygon.
REQ-008 SHALL have ports vx and vy, input, MAX_EDGES*COORD_W each, packed vertex coordinates with vertex i at bits [i*COORD_W +: COORD_W].
REQ-009 SHALL have port draw_done, input, 1, line-drawer completion of the current edge.
REQ-010 SHALL have port draw_en, output, 1, level request to the line drawer.
REQ-011 SHALL have ports x0, y0, x1, y1, output, COORD_W each, registered endpoints of the current edge.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port seq_done, output, 1, one-cycle pulse on shape completion.
REQ-014 SHALL have port seq_err, output, 1, one-cycle pulse on a rejected request.

Function
REQ-015 SHALL implement states IDLE, LOAD, DRAW, GAP, DONE, DONE_WAIT, held in an explicit state register.
REQ-016 In IDLE with seq_en=1 and valid edge_count, SHALL latch vx, vy and edge_count and go to LOAD.
REQ-017 In IDLE with seq_en=1 and edge_count of 0, 2 or >MAX_EDGES, SHALL pulse seq_err for 1 cycle, stay in IDLE and never assert draw_en.
REQ-018 In LOAD, SHALL set the edge index to 0, register edge-0 endpoints, and go to DRAW.
REQ-019 Edge i SHALL run from vertex i to vertex (i+1) mod edge_count; for edge_count=1 the only edge runs v0->v1.
REQ-020 In DRAW, SHALL hold draw_en=1 and keep x0..y1 stable until draw_done=1.
REQ-021 On draw_done in DRAW for a non-final edge, SHALL increment the edge index, register the next endpoints, and enter GAP, or enter DRAW directly when GAP_CYCLES=0.
REQ-022 On draw_done in DRAW for the final edge, SHALL go to DONE with no gap.
REQ-023 In GAP, SHALL hold draw_en=0 for exactly GAP_CYCLES cycles, then return to DRAW.
REQ-024 draw_done SHALL be ignored outside DRAW.
REQ-025 In DONE, SHALL pulse seq_done for 1 cycle, then pass through DONE_WAIT (all pulses low) to IDLE.
REQ-026 seq_en outside IDLE SHALL be ignored; it is not queued.
REQ-027 Request-to-first-draw_en latency SHALL be 2 cycles (IDLE->LOAD->DRAW).

Reset
REQ-028 On n_rst=0, SHALL force state to IDLE, the edge index and gap counter to 0, draw_en, busy, seq_done and seq_err to 0, and x0..y1 to 0, immediately and including mid-draw.

Configuration
REQ-029 When macro SEQ_ABORT_EN is defined, SHALL add input seq_abort (1) and output seq_aborted (1).
REQ-030 With SEQ_ABORT_EN, seq_abort=1 in any non-IDLE state SHALL go to IDLE next cycle, drop draw_en, pulse seq_aborted for 1 cycle, and suppress seq_done.
REQ-031 With SEQ_ABORT_EN, seq_abort SHALL take priority over a simultaneous draw_done; in IDLE, seq_abort SHALL have no effect.
REQ-032 Without SEQ_ABORT_EN, both ports SHALL be absent and the behaviour is otherwise identical.

Structure
REQ-033 The state enum typedef and the default parameter constants SHALL live in shared package gpu_draw_pkg.
REQ-034 The GAP cycle countdown SHALL be a sub-module, gap_timer (load, count, expire).

Verification
REQ-035 Line: edge_count=1, v0=(10,20), v1=(30,40), draw_done 5 cycles after draw_en -> one draw with x0,y0,x1,y1=10,20,30,40, then seq_done once.
REQ-036 Triangle, GAP_CYCLES=2: v=(0,0),(8,0),(4,6) -> edges (0,0)->(8,0), (8,0)->(4,6), (4,6)->(0,0); 2 low cycles between draws, none after the last.
REQ-037 Invalid request: edge_count=2 -> seq_err pulse, draw_en never high, busy stays 0.
REQ-038 Mid-draw reset: n_rst low during edge 2 of a quad -> all outputs 0 at once; new request after release starts at edge 0.
REQ-039 Busy ignore: seq_en re-asserted during DRAW -> no effect, exactly edge_count draws, one seq_done.
REQ-040 SEQ_ABORT_EN: seq_abort and draw_done in the same cycle on edge 1 -> IDLE, seq_aborted pulse, no seq_done, no further draw_en.

Source files
------------

// File: rtl/gpu_draw_pkg.sv
// Shared types and default parameters for the GPU drawing sequencers.
package gpu_draw_pkg;

  localparam int unsigned DefMaxEdges  = 4;
  localparam int unsigned DefCoordW    = 10;
  localparam int unsigned DefGapCycles = 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDraw,
    StGap,
    StDone,
    StDoneWait
  } seq_state_e;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter; expire is high on the last counted cycle.
module gap_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/polygon_draw_sequencer.sv
// Walks the edges of a latched polygon and hands each edge to a line drawer.
// Optional abort port pair is enabled by defining SEQ_ABORT_EN.
module polygon_draw_sequencer
  import gpu_draw_pkg::*;
#(
  parameter int unsigned MAX_EDGES  = DefMaxEdges,
  parameter int unsigned COORD_W    = DefCoordW,
  parameter int unsigned GAP_CYCLES = DefGapCycles
) (
  input  logic                              clk,
  input  logic                              n_rst,
`ifdef SEQ_ABORT_EN
  input  logic                              seq_abort,
  output logic                              seq_aborted,
`endif
  input  logic                              seq_en,
  input  logic [$clog2(MAX_EDGES+1)-1:0]    edge_count,
  input  logic [MAX_EDGES*COORD_W-1:0]      vx,
  input  logic [MAX_EDGES*COORD_W-1:0]      vy,
  input  logic                              draw_done,
  output logic                              draw_en,
  output logic [COORD_W-1:0]                x0,
  output logic [COORD_W-1:0]                y0,
  output logic [COORD_W-1:0]                x1,
  output logic [COORD_W-1:0]                y1,
  output logic                              busy,
  output logic                              seq_done,
  output logic                              seq_err
);

  localparam int unsigned EW = $clog2(MAX_EDGES + 1);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  seq_state_e                 state_q, state_d;
  logic [EW-1:0]              idx_q, idx_d, cnt_q;
  logic [MAX_EDGES*COORD_W-1:0] vx_q, vy_q;
  logic [COORD_W-1:0]         x0_q, y0_q, x1_q, y1_q;
  logic                       seq_err_q, err_d;
  logic                       latch, ep_load, gap_load, gap_count, gap_expire, abort;
  logic [EW-1:0]              ep_a, ep_b, nxt_a, nxt_b;
  logic                       last_edge, req_valid;

  function automatic logic [COORD_W-1:0] vsel(input logic [MAX_EDGES*COORD_W-1:0] v,
                                              input logic [EW-1:0] i);
    return v[int'(i)*COORD_W +: COORD_W];
  endfunction

`ifdef SEQ_ABORT_EN
  logic aborted_q;
  assign abort       = seq_abort;
  assign seq_aborted = aborted_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= seq_abort && (state_q != StIdle);
    end
  end
`else
  assign abort = 1'b0;
`endif

  assign req_valid = (edge_count == EW'(1)) ||
                     ((edge_count >= EW'(3)) && (edge_count <= EW'(MAX_EDGES)));
  // Closing edge wraps to vertex 0; the open segment has a single edge.
  assign last_edge = (cnt_q == EW'(1)) || (idx_q == cnt_q - EW'(1));
  assign nxt_a     = idx_q + EW'(1);
  assign nxt_b     = (nxt_a + EW'(1) == cnt_q) ? '0 : nxt_a + EW'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    latch     = 1'b0;
    ep_load   = 1'b0;
    ep_a      = nxt_a;
    ep_b      = nxt_b;
    err_d     = 1'b0;
    gap_load  = 1'b0;
    gap_count = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (seq_en) begin
          if (req_valid) begin
            latch   = 1'b1;
            state_d = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        idx_d   = '0;
        ep_load = 1'b1;
        ep_a    = EW'(0);
        ep_b    = EW'(1);
        state_d = StDraw;
      end
      StDraw: begin
        if (draw_done) begin
          if (last_edge) begin
            state_d = StDone;
          end else begin
            idx_d   = nxt_a;
            ep_load = 1'b1;
            if (GAP_CYCLES == 0) begin
              state_d = StDraw;
            end else begin
              gap_load = 1'b1;
              state_d  = StGap;
            end
          end
        end
      end
      StGap: begin
        gap_count = 1'b1;
        if (gap_expire) state_d = StDraw;
      end
      StDone:     state_d = StDoneWait;
      StDoneWait: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      ep_load  = 1'b0;
      gap_load = 1'b0;
    end
  end

  gap_timer #(
    .WIDTH(GW)
  ) u_gap_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (gap_load),
    .load_val(GW'(GAP_CYCLES)),
    .count   (gap_count),
    .expire  (gap_expire)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_err_q <= err_d;
      if (latch) begin
        vx_q  <= vx;
        vy_q  <= vy;
        cnt_q <= edge_count;
      end
      if (ep_load) begin
        x0_q <= vsel(vx_q, ep_a);
        y0_q <= vsel(vy_q, ep_a);
        x1_q <= vsel(vx_q, ep_b);
        y1_q <= vsel(vy_q, ep_b);
      end
    end
  end

  assign draw_en  = (state_q == StDraw);
  assign busy     = (state_q != StIdle);
  assign seq_done = (state_q == StDone) && !abort;
  assign seq_err  = seq_err_q;
  assign x0       = x0_q;
  assign y0       = y0_q;
  assign x1       = x1_q;
  assign y1       = y1_q;

endmodule

// File: tb/tb_polygon_draw_sequencer.sv
// Scoreboard bench: stimulus pushes expected draw/done/err events, a monitor pops and compares.
module tb_polygon_draw_sequencer;

  localparam int Gap = 2;
  localparam int EvDraw = 0, EvDone = 1, EvErr = 2, EvAbort = 3;

  typedef struct {
    int          kind;
    logic [39:0] data;
  } ev_t;

  logic        clk, n_rst, seq_en, draw_done, resp_done, man_done;
  logic [2:0]  edge_count;
  logic [39:0] vx, vy;
  logic        draw_en, busy, seq_done, seq_err;
  logic [9:0]  x0, y0, x1, y1;
`ifdef SEQ_ABORT_EN
  logic        seq_abort, seq_aborted;
`endif

  ev_t exp_q[$];
  int  errors = 0, checks = 0, draws_seen = 0;
  int  fixed_dly = -1;
  bit  noise = 1'b0;
  int  mvx[4], mvy[4];

  assign draw_done = resp_done | man_done;

  polygon_draw_sequencer #(
    .MAX_EDGES (4),
    .COORD_W   (10),
    .GAP_CYCLES(Gap)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
`ifdef SEQ_ABORT_EN
    .seq_abort  (seq_abort),
    .seq_aborted(seq_aborted),
`endif
    .seq_en    (seq_en),
    .edge_count(edge_count),
    .vx        (vx),
    .vy        (vy),
    .draw_done (draw_done),
    .draw_en   (draw_en),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .busy      (busy),
    .seq_done  (seq_done),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [39:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %0h, required none", kind, data);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      check("event_data", 64'(data), 64'(e.data));
    end
  endtask

  // Monitor: decodes DUT activity into events and checks gap length / endpoint stability.
  initial begin
    logic        prev_en;
    logic        had;
    int          gap;
    logic [39:0] cur;
    prev_en = 1'b0; had = 1'b0; gap = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_en = 1'b0; had = 1'b0; gap = 0;
      end else begin
        if (draw_en && !prev_en) begin
          if (had) check("gap_len", 64'(gap), 64'(Gap));
          had = 1'b1;
          gap = 0;
          cur = {x0, y0, x1, y1};
          draws_seen++;
          expect_ev(EvDraw, cur);
        end else if (draw_en) begin
          check("endpoints_stable", 64'({x0, y0, x1, y1}), 64'(cur));
        end
        if (seq_done) begin
          check("no_tail_gap", 64'(gap), 64'd0);
          expect_ev(EvDone, '0);
          had = 1'b0;
        end
        if (seq_err) begin
          check("err_not_busy", 64'(busy), 64'd0);
          expect_ev(EvErr, '0);
        end
`ifdef SEQ_ABORT_EN
        if (seq_aborted) expect_ev(EvAbort, '0);
`endif
        if (!busy) had = 1'b0;
        if (busy && !draw_en && !seq_done && had) gap++;
        prev_en = draw_en;
      end
    end
  end

  // Line-drawer stand-in: completes after a delay, optionally toggles draw_done while idle.
  initial begin
    int rcnt, rdly;
    resp_done = 1'b0; rcnt = 0; rdly = 0;
    forever begin
      @(negedge clk);
      if (!draw_en) begin
        rcnt = 0;
        rdly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
        resp_done = noise && ($urandom_range(0, 3) == 0);
      end else begin
        resp_done = (rcnt == rdly);
        rcnt++;
      end
    end
  end

  task automatic issue(input int n, input bit poke);
    logic [39:0] pvx, pvy;
    bit          valid;
    int          m, b;
    for (int i = 0; i < 4; i++) begin
      pvx[i*10 +: 10] = 10'(mvx[i]);
      pvy[i*10 +: 10] = 10'(mvy[i]);
    end
    valid = (n == 1) || (n >= 3 && n <= 4);
    if (valid) begin
      m = (n == 1) ? 1 : n;
      for (int i = 0; i < m; i++) begin
        b = (n == 1) ? 1 : (i + 1) % n;
        exp_q.push_back('{EvDraw, {10'(mvx[i]), 10'(mvy[i]), 10'(mvx[b]), 10'(mvy[b])}});
      end
      exp_q.push_back('{EvDone, 40'd0});
    end else begin
      exp_q.push_back('{EvErr, 40'd0});
    end
    @(negedge clk);
    seq_en = 1'b1; edge_count = 3'(n); vx = pvx; vy = pvy;
    @(posedge clk); #1;
    if (valid) begin
      check("load_busy", 64'(busy), 64'd1);
      check("load_no_draw", 64'(draw_en), 64'd0);
    end else begin
      check("err_busy_low", 64'(busy), 64'd0);
    end
    if (!poke) begin
      seq_en = 1'b0;
    end else begin
      edge_count = 3'($urandom_range(1, 4));
      vx = 40'({$urandom, $urandom});
      vy = 40'({$urandom, $urandom});
    end
    @(posedge clk); #1;
    check("first_draw_latency", 64'(draw_en), valid ? 64'd1 : 64'd0);
    if (poke) begin
      repeat (2) @(posedge clk);
      #1 seq_en = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: %0d events pending busy=%0d, required 0 and idle", exp_q.size(), busy);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_draws(input int target);
    int t = 0;
    while (draws_seen < target && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (draws_seen < target) begin
      checks++;
      errors++;
      $display("FAIL wait_draws: saw %0d draws, required %0d", draws_seen, target);
    end
  endtask

  task automatic set_verts(input int a0, b0, a1, b1, a2, b2, a3, b3);
    mvx[0] = a0; mvy[0] = b0; mvx[1] = a1; mvy[1] = b1;
    mvx[2] = a2; mvy[2] = b2; mvx[3] = a3; mvy[3] = b3;
  endtask

  initial begin
    int n, base;
    n_rst = 1'b0; seq_en = 1'b0; edge_count = '0; vx = '0; vy = '0; man_done = 1'b0;
`ifdef SEQ_ABORT_EN
    seq_abort = 1'b0;
`endif
    #1;
    check("reset_outputs", 64'({draw_en, busy, seq_done, seq_err, x0, y0, x1, y1}), 64'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    // Open segment, fixed drawer latency.
    fixed_dly = 5;
    set_verts(10, 20, 30, 40, 0, 0, 0, 0);
    issue(1, 1'b0);
    wait_idle();
    fixed_dly = -1;

    // Closed triangle with two-cycle gaps.
    set_verts(0, 0, 8, 0, 4, 6, 0, 0);
    issue(3, 1'b0);
    wait_idle();

    // Rejected request: no draw, never busy.
    issue(2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("invalid_idle", 64'({busy, draw_en}), 64'd0);
    end
    wait_idle();

    // Re-request while busy must not restart or queue.
    noise = 1'b1;
    set_verts(1, 2, 3, 4, 5, 6, 7, 8);
    issue(4, 1'b1);
    wait_idle();

    for (int k = 0; k < 12; k++) begin
      n = int'($urandom_range(0, 7));
      for (int i = 0; i < 4; i++) begin
        mvx[i] = int'($urandom_range(0, 1023));
        mvy[i] = int'($urandom_range(0, 1023));
      end
      issue(n, (n >= 3 && n <= 4) && ($urandom_range(0, 1) == 1));
      wait_idle();
    end

    // Asynchronous reset in the middle of edge 2 of a quad.
    fixed_dly = 3;
    set_verts(100, 200, 300, 400, 500, 600, 700, 800);
    base = draws_seen;
    issue(4, 1'b0);
    wait_draws(base + 3);
    #3;
    check("pre_reset_drawing", 64'(draw_en), 64'd1);
    n_rst = 1'b0;
    #1;
    check("midreset_outputs", 64'({draw_en, busy, seq_done, seq_err, x0, y0, x1, y1}), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    fixed_dly = -1;
    issue(4, 1'b0);
    wait_idle();

`ifdef SEQ_ABORT_EN
    // Abort coincident with draw_done on edge 1; then abort in IDLE is a no-op.
    fixed_dly = 100;
    set_verts(0, 0, 8, 0, 4, 6, 0, 0);
    base = draws_seen;
    issue(3, 1'b0);
    wait_draws(base + 2);
    #1;
    exp_q.delete();
    exp_q.push_back('{EvAbort, 40'd0});
    man_done = 1'b1; seq_abort = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0; seq_abort = 1'b0;
    check("abort_to_idle", 64'({busy, draw_en, seq_done}), 64'd0);
    fixed_dly = -1;
    wait_idle();
    @(negedge clk); seq_abort = 1'b1;
    @(posedge clk); #1; seq_abort = 1'b0;
    check("abort_in_idle", 64'({busy, seq_aborted}), 64'd0);
    wait_idle();
`endif

    noise = 1'b0;
    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_events: %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
